mips_result_capture: RTL and testbench

- Downstream observer for SingleCycleClockMIPS: samples the processor's 32-bit Result bus every cycle and captures only value changes.
- Each change is tagged with a sequence number and buffered in a show-ahead FIFO. A bench, or a later UART/debug stage, drains the FIFO with a valid/ready handshake.
- Also keeps a running signature and a drop counter, so a long program run can be checked without a waveform dump.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mips_result_capture_if.sv | 39 +++
 rtl/mips_result_capture_fifo.sv | 89 ++++++++
 rtl/mips_result_capture.sv | 136 +++++++++++++
 tb/tb_mips_result_capture.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the SingleCycleClockMIPS result-capture slice.
//   - Default widths and depth used by the capture block and its FIFO.
//   - Entry layout: {seq[SEQ_W-1:0], data[DATA_W-1:0]}, seq in the upper bits.
//   - sig_step(): one step of the running signature (rotate left by 1, then XOR).
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEQ_W  = 16;
  localparam int DEF_DEPTH  = 16;
  localparam int DROP_W     = 16;

  // Entry layout at the default widths; seq sits above data.
  typedef struct packed {
    logic [DEF_SEQ_W-1:0]  seq;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  // One signature step: rotate the old signature left by one bit, fold in data.
  function automatic logic [DEF_DATA_W-1:0] sig_step(
    input logic [DEF_DATA_W-1:0] sig,
    input logic [DEF_DATA_W-1:0] data
  );
    sig_step = {sig[DEF_DATA_W-2:0], sig[DEF_DATA_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/mips_result_capture_if.sv
// Bundle of the capture block's data-path signals.
//   master : the side that drives the Result bus and the drain handshake
//            (processor + consumer, or a bench).
//   slave  : the capture block itself.
// Signals:
//   result_in  - processor Result bus         run_en     - capture enable
//   out_ready  - consumer accepts head entry  out_valid  - head entry present
//   out_data   - head entry data              out_seq    - head entry sequence tag
//   count      - FIFO occupancy 0..DEPTH      full       - count == DEPTH
//   drop_count - events lost while full       signature  - running signature
interface mips_result_capture_if #(
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 16,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] result_in;
  logic              run_en;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEQ_W-1:0]  out_seq;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic [15:0]       drop_count;
  logic [DATA_W-1:0] signature;

  modport master (
    output result_in, run_en, out_ready,
    input  out_valid, out_data, out_seq, count, full, drop_count, signature
  );

  modport slave (
    input  result_in, run_en, out_ready,
    output out_valid, out_data, out_seq, count, full, drop_count, signature
  );

endinterface

// File: rtl/mips_result_capture_fifo.sv
// sync_fifo_sa: synchronous show-ahead FIFO.
// The head entry is presented on rdata straight from the read pointer, so a
// consumer sees it in the same cycle it becomes the oldest entry.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push/wdata - write request and data (ignored when full without a pop)
//   pop        - remove head (ignored when empty)
//   rdata      - head entry (only meaningful while !empty)
//   count      - occupancy 0..DEPTH; full/empty derived from it
module sync_fifo_sa #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             full_s;
  logic             empty_s;

  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign empty_s   = (count_q == {CNT_W{1'b0}});
  assign pop_ok_s  = pop & ~empty_s;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok_s = push & (~full_s | pop_ok_s);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the FIFO regardless of memory contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; not reset because stale words are never read while empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/mips_result_capture.sv
// mips_result_capture: observer on the SingleCycleClockMIPS Result bus.
// Captures each change of result_in (and the first sample after reset) while
// run_en is high, tags it with a sequence number and queues {seq, data} in a
// show-ahead FIFO drained by out_valid/out_ready. Also keeps a saturating
// count of events lost to a full FIFO and a rotate/XOR signature of every
// accepted event.
// Ports:
//   CLK - rising-edge clock
//   RST - asynchronous active-high reset; clears all state including the FIFO
//   bus - mips_result_capture_if.slave (result_in, run_en, out_ready in;
//         out_valid, out_data, out_seq, count, full, drop_count, signature out)
module mips_result_capture
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  mips_result_capture_if.slave  bus
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = SEQ_W + DATA_W;

  logic [DATA_W-1:0]  prev_q, prev_d;
  logic               seen_first_q, seen_first_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [DATA_W-1:0]  sig_q, sig_d;
  logic [DATA_W-1:0]  sig_step_s;

  logic               event_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_s;
  logic [ENTRY_W-1:0] fifo_wdata_s;
  logic [ENTRY_W-1:0] fifo_rdata_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  // The very first enabled sample is always an event, even if it equals the
  // reset value of prev_q.
  assign event_s = bus.run_en & (~seen_first_q | (bus.result_in != prev_q));
  assign pop_s   = ~fifo_empty_s & bus.out_ready;
  assign push_s  = event_s & (~fifo_full_s | pop_s);
  assign drop_s  = event_s & ~push_s;

  assign fifo_wdata_s = {seq_q, bus.result_in};

  // Use the shared package step at the default width so the signature
  // definition lives in one place; other widths use the same formula inline.
  generate
    if (DATA_W == DEF_DATA_W) begin : g_sig_pkg
      assign sig_step_s = sig_step(sig_q, bus.result_in);
    end else begin : g_sig_gen
      assign sig_step_s = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ bus.result_in;
    end
  endgenerate

  // Next-state for sampler, sequence tag, drop counter and signature.
  always_comb begin
    prev_d       = prev_q;
    seen_first_d = seen_first_q;
    seq_d        = seq_q;
    drop_d       = drop_q;
    sig_d        = sig_q;
    if (bus.run_en) begin
      prev_d       = bus.result_in;
      seen_first_d = 1'b1;
    end else begin
      prev_d       = prev_q;
      seen_first_d = seen_first_q;
    end
    // Dropped events still consume a tag so gaps in seq reveal losses.
    if (event_s) begin
      seq_d = seq_q + SEQ_W'(1);
    end else begin
      seq_d = seq_q;
    end
    if (drop_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
    if (push_s) begin
      sig_d = sig_step_s;
    end else begin
      sig_d = sig_q;
    end
  end

  // Capture-side state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q       <= {DATA_W{1'b0}};
      seen_first_q <= 1'b0;
      seq_q        <= {SEQ_W{1'b0}};
      drop_q       <= {DROP_W{1'b0}};
      sig_q        <= {DATA_W{1'b0}};
    end else begin
      prev_q       <= prev_d;
      seen_first_q <= seen_first_d;
      seq_q        <= seq_d;
      drop_q       <= drop_d;
      sig_q        <= sig_d;
    end
  end

  sync_fifo_sa #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Head fields are forced to zero while empty so reset shows clean outputs
  // even though the storage array itself is not cleared.
  assign bus.out_valid  = ~fifo_empty_s;
  assign bus.out_data   = fifo_empty_s ? {DATA_W{1'b0}} : fifo_rdata_s[DATA_W-1:0];
  assign bus.out_seq    = fifo_empty_s ? {SEQ_W{1'b0}}  : fifo_rdata_s[ENTRY_W-1:DATA_W];
  assign bus.count      = fifo_count_s;
  assign bus.full       = fifo_full_s;
  assign bus.drop_count = drop_q;
  assign bus.signature  = sig_q;

endmodule

// File: tb/tb_mips_result_capture.sv
`timescale 1ns/1ps
module tb_mips_result_capture;
  import mips_pkg::*;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  mips_result_capture_if #(.DATA_W(32), .SEQ_W(16), .DEPTH(16)) bus ();
  mips_result_capture_if #(.DATA_W(32), .SEQ_W(4),  .DEPTH(16)) bus4 ();

  mips_result_capture #(.DATA_W(32), .DEPTH(16), .SEQ_W(16)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  mips_result_capture #(.DATA_W(32), .DEPTH(16), .SEQ_W(4)) u_dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus.run_en     = 1'b0;
    bus.out_ready  = 1'b0;
    bus.result_in  = 32'h0;
    bus4.run_en    = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.result_in = 32'h0;
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    bus.run_en    = 1'b1;
    bus.result_in = 32'h0;
    bus.out_ready = 1'b0;
    bus4.run_en   = 1'b0;
    RST = 1'b1;
    step();
    step();
    checks++;
    if (bus.count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.full !== 1'b0) begin failures++; $display("FAIL rst_valid_full got=%b%b exp=00", bus.out_valid, bus.full); end
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_seq !== 16'h0) begin failures++; $display("FAIL rst_head got=%h/%h exp=0/0", bus.out_seq, bus.out_data); end
    checks++;
    if (bus.drop_count !== 16'h0 || bus.signature !== 32'h0) begin failures++; $display("FAIL rst_drop_sig got=%h/%h exp=0/0", bus.drop_count, bus.signature); end
    RST = 1'b0;
    step();
    step();
    step();
    checks++;
    if (bus.count !== 5'd1) begin failures++; $display("FAIL first_count got=%0d exp=1", bus.count); end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'd0 || bus.out_data !== 32'h0) begin
      failures++; $display("FAIL first_entry got=%b %h/%h exp=1 0/0", bus.out_valid, bus.out_seq, bus.out_data);
    end
    checks++;
    if (bus.signature !== 32'h0) begin failures++; $display("FAIL first_sig got=%h exp=0", bus.signature); end
  endtask

  task automatic test_change_capture();
    logic [31:0] vals [5];
    logic        is_ev [5];
    logic [15:0] exp_seq;
    vals  = '{32'h5, 32'h5, 32'hA, 32'hA, 32'h3};
    is_ev = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus.run_en    = 1'b1;
    bus.out_ready = 1'b1;
    exp_seq = 16'd0;
    for (int i = 0; i < 5; i++) begin
      bus.result_in = vals[i];
      step();
      if (is_ev[i]) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_seq !== exp_seq || bus.out_data !== vals[i]) begin
          failures++; $display("FAIL chg_head%0d got=%b %h/%h exp=1 %h/%h", i, bus.out_valid, bus.out_seq, bus.out_data, exp_seq, vals[i]);
        end
        exp_seq = exp_seq + 16'd1;
      end else begin
        checks++;
        if (bus.count !== 5'd0) begin failures++; $display("FAIL chg_nochange%0d got=%0d exp=0", i, bus.count); end
      end
    end
    // rotl(rotl(0)^5)^A = 0, then rotl(0)^3 = 3
    checks++;
    if (bus.signature !== 32'h00000003) begin failures++; $display("FAIL chg_sig got=%h exp=00000003", bus.signature); end
  endtask

  task automatic test_overflow();
    logic [31:0] sig_m;
    logic [15:0] exp_seq;
    logic [31:0] exp_data;
    do_reset();
    bus.run_en    = 1'b1;
    bus.out_ready = 1'b0;
    sig_m = 32'h0;
    for (int i = 0; i < 20; i++) begin
      bus.result_in = 32'(i + 1);
      if (i < 16) sig_m = sig_step(sig_m, 32'(i + 1));
      step();
    end
    checks++;
    if (bus.count !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%0d/%b exp=16/1", bus.count, bus.full); end
    checks++;
    if (bus.drop_count !== 16'd4) begin failures++; $display("FAIL ovf_drop got=%0d exp=4", bus.drop_count); end
    checks++;
    if (bus.out_seq !== 16'd0 || bus.out_data !== 32'd1) begin failures++; $display("FAIL ovf_head got=%h/%h exp=0/1", bus.out_seq, bus.out_data); end
    checks++;
    if (bus.signature !== sig_m) begin failures++; $display("FAIL ovf_sig got=%h exp=%h", bus.signature, sig_m); end
    // Push while full with a simultaneous pop: tag 20 since four were dropped.
    bus.result_in = 32'd21;
    bus.out_ready = 1'b1;
    sig_m = sig_step(sig_m, 32'd21);
    step();
    bus.run_en = 1'b0;
    checks++;
    if (bus.count !== 5'd16 || bus.drop_count !== 16'd4) begin failures++; $display("FAIL ovf_accept got=%0d/%0d exp=16/4", bus.count, bus.drop_count); end
    checks++;
    if (bus.signature !== sig_m) begin failures++; $display("FAIL ovf_accept_sig got=%h exp=%h", bus.signature, sig_m); end
    for (int k = 0; k < 16; k++) begin
      exp_seq  = (k < 15) ? 16'(k + 1) : 16'd20;
      exp_data = (k < 15) ? 32'(k + 2) : 32'd21;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_seq !== exp_seq || bus.out_data !== exp_data) begin
        failures++; $display("FAIL ovf_drain%0d got=%b %h/%h exp=1 %h/%h", k, bus.out_valid, bus.out_seq, bus.out_data, exp_seq, exp_data);
      end
      step();
    end
    checks++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0 || bus.full !== 1'b0) begin
      failures++; $display("FAIL ovf_empty got=%0d/%b/%b exp=0/0/0", bus.count, bus.out_valid, bus.full);
    end
  endtask

  task automatic test_run_en_gating();
    do_reset();
    bus.out_ready = 1'b0;
    bus.run_en    = 1'b1;
    bus.result_in = 32'h100;
    step();
    bus.run_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.result_in = 32'hBEEF0000 + 32'(i);
      step();
    end
    checks++;
    if (bus.count !== 5'd1) begin failures++; $display("FAIL gate_idle got=%0d exp=1", bus.count); end
    bus.run_en    = 1'b1;
    bus.result_in = 32'h100;
    step();
    checks++;
    if (bus.count !== 5'd1) begin failures++; $display("FAIL gate_same got=%0d exp=1", bus.count); end
    bus.result_in = 32'h200;
    step();
    bus.run_en = 1'b0;
    checks++;
    if (bus.count !== 5'd2) begin failures++; $display("FAIL gate_new got=%0d exp=2", bus.count); end
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_seq !== 16'd0 || bus.out_data !== 32'h100) begin failures++; $display("FAIL gate_head0 got=%h/%h exp=0/100", bus.out_seq, bus.out_data); end
    step();
    checks++;
    if (bus.out_seq !== 16'd1 || bus.out_data !== 32'h200) begin failures++; $display("FAIL gate_head1 got=%h/%h exp=1/200", bus.out_seq, bus.out_data); end
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.out_ready = 1'b0;
    bus.run_en    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.result_in = 32'h40 + 32'(i);
      step();
    end
    checks++;
    if (bus.count !== 5'd5 || bus.signature === 32'h0) begin failures++; $display("FAIL mid_pre got=%0d/%h exp=5/nonzero", bus.count, bus.signature); end
    RST = 1'b1;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_async got=%0d/%b exp=0/0", bus.count, bus.out_valid); end
    checks++;
    if (bus.drop_count !== 16'h0 || bus.signature !== 32'h0) begin failures++; $display("FAIL mid_async_sig got=%h/%h exp=0/0", bus.drop_count, bus.signature); end
    step();
    RST = 1'b0;
    bus.result_in = 32'h77;
    step();
    checks++;
    if (bus.count !== 5'd1 || bus.out_seq !== 16'd0 || bus.out_data !== 32'h77) begin
      failures++; $display("FAIL mid_after got=%0d %h/%h exp=1 0/77", bus.count, bus.out_seq, bus.out_data);
    end
  endtask

  task automatic test_seq_wrap();
    logic [3:0] exp_seq;
    do_reset();
    bus4.run_en    = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus4.result_in = 32'h1000 + 32'(i);
      step();
      exp_seq = 4'(i);
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_seq !== exp_seq || bus4.out_data !== 32'h1000 + 32'(i) || bus4.count !== 5'd1) begin
        failures++; $display("FAIL wrap%0d got=%b %h/%h c=%0d exp=1 %h/%h c=1", i, bus4.out_valid, bus4.out_seq, bus4.out_data, bus4.count, exp_seq, 32'h1000 + 32'(i));
      end
    end
    bus4.run_en = 1'b0;
    step();
    checks++;
    if (bus4.drop_count !== 16'd0 || bus4.count !== 5'd0) begin failures++; $display("FAIL wrap_end got=%0d/%0d exp=0/0", bus4.drop_count, bus4.count); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST            = 1'b1;
    bus.run_en     = 1'b0;
    bus.out_ready  = 1'b0;
    bus.result_in  = 32'h0;
    bus4.run_en    = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.result_in = 32'h0;
    test_reset();
    test_change_capture();
    test_overflow();
    test_run_en_gating();
    test_mid_reset();
    test_seq_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
